// File: rtl/mux4_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux4_scan_sequencer
//
// Purpose:
//   Steps an external 4:1 analog/digital mux through the channels enabled in a
//   latched mask. Each channel select is held for SETTLE cycles, then the mux
//   output is captured into the matching frame bit. When the last enabled
//   channel has been sampled, the frame is presented with frame_valid and held
//   until the consumer accepts it with frame_ready.
//
// Parameters:
//   SETTLE       cycles each select is held before sampling (1..15)
//
// Ports:
//   clk          single clock, rising-edge
//   rst          asynchronous, active-high reset
//   start        scan request, only looked at while idle
//   ch_mask[3:0] channel enables, latched when a scan is accepted
//   mux_y        returned data from the downstream mux
//   sel[1:0]     mux select (registered)
//   busy         high while channels are being settled/sampled
//   frame[3:0]   captured samples, bit i belongs to channel i
//   frame_valid  frame complete and stable
//   frame_ready  consumer accepts the frame (only looked at while holding)
//
// States:
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | waiting for start; sel and frame keep their last values
//   S_SETTLE  | sel driven, counting settle cycles, sample on last cycle
//   S_HOLD    | frame complete, frame_valid high, waiting for frame_ready
// -----------------------------------------------------------------------------
module mux4_scan_sequencer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] ch_mask,
  input  logic       mux_y,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  // Counter value on the cycle the sample is taken.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] mask_q;

  logic [1:0] first_sel;
  logic [1:0] next_sel;
  logic       has_next;

  // first_sel: lowest enabled channel of the incoming mask (used at start).
  // next_sel : lowest enabled channel strictly above the current select in the
  //            latched mask; has_next is low when the current one is the last.
  // Loops run high-to-low so the last hit wins, i.e. the lowest index.
  always_comb begin
    first_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_sel = 2'(i);
      end
    end

    has_next = 1'b0;
    next_sel = sel;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel))) begin
        has_next = 1'b1;
        next_sel = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sel         <= 2'b00;
      busy        <= 1'b0;
      frame       <= 4'b0000;
      frame_valid <= 1'b0;
      cnt         <= 4'd0;
      mask_q      <= 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q <= ch_mask;
            frame  <= 4'b0000;
            cnt    <= 4'd0;
            if (ch_mask == 4'b0000) begin
              // Nothing to scan: present an all-zero frame immediately,
              // leaving sel where it was.
              state       <= S_HOLD;
              frame_valid <= 1'b1;
            end else begin
              state <= S_SETTLE;
              sel   <= first_sel;
              busy  <= 1'b1;
            end
          end
        end

        S_SETTLE: begin
          if (cnt == CNT_LAST) begin
            frame[sel] <= mux_y;
            cnt        <= 4'd0;
            if (has_next) begin
              sel <= next_sel;
            end else begin
              state       <= S_HOLD;
              busy        <= 1'b0;
              frame_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        S_HOLD: begin
          // start is deliberately not looked at here, even alongside
          // frame_ready; a new scan needs start while idle.
          if (frame_ready) begin
            state       <= S_IDLE;
            frame_valid <= 1'b0;
          end
        end

        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          frame_valid <= 1'b0;
          cnt         <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_scan_sequencer.sv
module tb_mux4_scan_sequencer;

  localparam int ST = 2;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // main instance, SETTLE = 2
  logic       start, frame_ready, mux_y;
  logic [3:0] ch_mask, d_pat;
  logic [1:0] sel;
  logic       busy, frame_valid;
  logic [3:0] frame;

  // second instance, SETTLE = 1
  logic       start_b, ready_b, mux_y_b;
  logic [3:0] mask_b, d_b;
  logic [1:0] sel_b;
  logic       busy_b, fv_b;
  logic [3:0] frame_b;

  assign mux_y   = d_pat[sel];
  assign mux_y_b = d_b[sel_b];

  mux4_scan_sequencer #(.SETTLE(ST)) u_dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .mux_y(mux_y),
    .sel(sel), .busy(busy), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready)
  );

  mux4_scan_sequencer #(.SETTLE(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .ch_mask(mask_b), .mux_y(mux_y_b),
    .sel(sel_b), .busy(busy_b), .frame(frame_b), .frame_valid(fv_b),
    .frame_ready(ready_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a scan is a list of enabled channels; after k edges since
  // the start edge the scan is on list entry k/ST, and entry j is sampled on
  // edge (j+1)*ST using the mux data pattern at the expected select.
  // ---------------------------------------------------------------------------
  logic       m_active, m_hold;
  int         m_k;
  int         m_j;
  logic [1:0] m_list[$];
  logic [1:0] m_sel;
  logic [3:0] m_frame;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_hold   = 1'b0;
      m_k      = 0;
      m_list.delete();
      m_sel    = 2'd0;
      m_frame  = 4'd0;
    end else if (m_hold) begin
      if (frame_ready) m_hold = 1'b0;
    end else if (m_active) begin
      m_k++;
      if (m_k % ST == 0) begin
        m_j = m_k / ST - 1;
        m_frame[m_list[m_j]] = d_pat[m_sel];
        if (m_j + 1 < m_list.size()) begin
          m_sel = m_list[m_j + 1];
        end else begin
          m_active = 1'b0;
          m_hold   = 1'b1;
        end
      end
    end else if (start) begin
      m_list.delete();
      for (int i = 0; i < 4; i++) if (ch_mask[i]) m_list.push_back(2'(i));
      m_frame = 4'd0;
      m_k     = 0;
      if (m_list.size() == 0) begin
        m_hold = 1'b1;
      end else begin
        m_active = 1'b1;
        m_sel    = m_list[0];
      end
    end
  end

  logic cmp_on = 1'b0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("sel",         int'(sel),         int'(m_sel));
      chk("busy",        int'(busy),        int'(m_active));
      chk("frame",       int'(frame),       int'(m_frame));
      chk("frame_valid", int'(frame_valid), int'(m_hold));
    end
  end

  task automatic kick(input logic [3:0] mask, input logic [3:0] d);
    @(negedge clk);
    ch_mask = mask;
    d_pat   = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    ch_mask = ~mask;   // must not affect the scan in flight
  endtask

  task automatic release_frame();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; frame_ready = 1'b0; ch_mask = 4'd0; d_pat = 4'd0;
    start_b = 1'b0; ready_b = 1'b0; mask_b = 4'd0; d_b = 4'd0;
    #1 rst = 1'b1;
    #2;
    chk("rst_sel",   int'(sel),         0);
    chk("rst_busy",  int'(busy),        0);
    chk("rst_frame", int'(frame),       0);
    chk("rst_fv",    int'(frame_valid), 0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    cmp_on = 1'b1;

    // Full 4-channel scan, D=1010
    kick(4'b1111, 4'b1010);
    for (int k = 0; k <= 8; k++) begin
      if (k % 2 == 0 && k < 8) chk("s4_sel", int'(sel), k / 2);
      if (k == 7) chk("s4_fv_early", int'(frame_valid), 0);
      if (k == 8) begin
        chk("s4_fv",    int'(frame_valid), 1);
        chk("s4_frame", int'(frame),       4'b1010);
      end
      if (k < 8) @(negedge clk);
    end

    // HOLD stability with start/mux_y toggling
    for (int i = 0; i < 5; i++) begin
      start = ~start;
      d_pat = ~d_pat;
      @(negedge clk);
      chk("hold_frame", int'(frame),       4'b1010);
      chk("hold_sel",   int'(sel),         3);
      chk("hold_fv",    int'(frame_valid), 1);
    end
    frame_ready = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    start       = 1'b0;
    chk("rel_fv",   int'(frame_valid), 0);
    chk("rel_busy", int'(busy),        0);
    @(negedge clk);
    chk("idle_busy",  int'(busy),  0);
    chk("idle_frame", int'(frame), 4'b1010);

    // Sparse mask 0101, D=1111
    kick(4'b0101, 4'b1111);
    for (int k = 0; k <= 4; k++) begin
      if (k == 0) chk("s2_sel0", int'(sel), 0);
      if (k == 2) chk("s2_sel2", int'(sel), 2);
      if (k == 3) chk("s2_fv_early", int'(frame_valid), 0);
      if (k == 4) begin
        chk("s2_fv",    int'(frame_valid), 1);
        chk("s2_frame", int'(frame),       4'b0101);
      end
      if (k < 4) @(negedge clk);
    end
    release_frame();

    // Empty mask
    kick(4'b0000, 4'b1111);
    chk("s0_fv",    int'(frame_valid), 1);
    chk("s0_busy",  int'(busy),        0);
    chk("s0_frame", int'(frame),       0);
    release_frame();

    // Async reset during channel 2
    kick(4'b1111, 4'b1111);
    repeat (4) @(negedge clk);
    chk("ar_sel_before", int'(sel), 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_sel",   int'(sel),         0);
    chk("ar_busy",  int'(busy),        0);
    chk("ar_frame", int'(frame),       0);
    chk("ar_fv",    int'(frame_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("ar_no_fv", int'(frame_valid), 0);
    end

    // Randomized traffic; inputs change just after the falling edge
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      start       = ($urandom_range(0, 3) == 0);
      ch_mask     = 4'($urandom);
      d_pat       = 4'($urandom);
      frame_ready = ($urandom_range(0, 2) == 0);
      rst         = ($urandom_range(0, 80) == 0);
    end
    @(negedge clk);
    #1;
    rst = 1'b0; start = 1'b0; frame_ready = 1'b0;
    repeat (2) @(negedge clk);

    // SETTLE = 1 instance
    start_b = 1'b1; mask_b = 4'b1000; d_b = 4'b1000;
    @(negedge clk);
    start_b = 1'b0;
    chk("b1_sel",  int'(sel_b),  3);
    chk("b1_busy", int'(busy_b), 1);
    chk("b1_fv0",  int'(fv_b),   0);
    @(negedge clk);
    chk("b1_fv",    int'(fv_b),    1);
    chk("b1_frame", int'(frame_b), 4'b1000);
    chk("b1_busy0", int'(busy_b),  0);
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    chk("b1_rel", int'(fv_b), 0);

    start_b = 1'b1; mask_b = 4'b1111; d_b = 4'b0110;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) chk("b4_sel", int'(sel_b), k);
      if (k == 3) chk("b4_fv_early", int'(fv_b), 0);
      if (k == 4) begin
        chk("b4_fv",    int'(fv_b),    1);
        chk("b4_frame", int'(frame_b), 4'b0110);
      end
      if (k < 4) @(negedge clk);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
